// File: rtl/cc_microsequencer.sv
// cc_microsequencer: hard-wired fetch/decode/execute sequencer for the register-file scratchpad datapath
module cc_microsequencer #(
  parameter int DATAWIDTH_BUS_REG_IR        = 5,
  parameter int DATAWIDTH_BUS_REG_IR_OP     = 8,
  parameter int DATAWIDTH_DECODER_SELECTION = 4,
  parameter int DATAWIDTH_MUX_SELECTION     = 4,
  parameter int DATAWIDTH_ALU_SELECTION     = 4,
  parameter int DATAWIDTH_COUNTER           = 16
) (
  input  logic                                   CC_MICROSEQUENCER_CLOCK_50,
  input  logic                                   CC_MICROSEQUENCER_RESET_InLow,
  input  logic [DATAWIDTH_BUS_REG_IR_OP-1:0]     CC_MICROSEQUENCER_IR_OP,
  input  logic [DATAWIDTH_BUS_REG_IR-1:0]        CC_MICROSEQUENCER_IR_RS1,
  input  logic [DATAWIDTH_BUS_REG_IR-1:0]        CC_MICROSEQUENCER_IR_RS2,
  input  logic [DATAWIDTH_BUS_REG_IR-1:0]        CC_MICROSEQUENCER_IR_RD,
  input  logic                                   CC_MICROSEQUENCER_IR_IR13,
  input  logic                                   CC_MICROSEQUENCER_MemAck_In,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_MICROSEQUENCER_Decoder_Selection_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     CC_MICROSEQUENCER_MUXA_Selection_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     CC_MICROSEQUENCER_MUXB_Selection_Out,
  output logic                                   CC_MICROSEQUENCER_MUXC_Selection_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     CC_MICROSEQUENCER_ALU_Op_Out,
  output logic                                   CC_MICROSEQUENCER_MemReq_Out,
  output logic                                   CC_MICROSEQUENCER_MemWrite_Out,
  output logic                                   CC_MICROSEQUENCER_Halt_Out,
  output logic [DATAWIDTH_COUNTER-1:0]           CC_MICROSEQUENCER_Retired_Out
);
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM, S_PCINC, S_HALT
  } state_t;
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] D_NONE = '1;
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] D_PC   = 8;
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] D_T0   = 9;
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] D_IR   = 13;
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0]     M_PC   = 8;
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0]     M_T0   = 9;
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0]     M_SIMM = 14;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0]     A_ADD  = 0;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0]     A_INC4 = 5;
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0]     A_PASSA = 6;
  state_t state, state_nx;
  logic [DATAWIDTH_COUNTER-1:0] retired;
  logic [1:0] op;
  logic [5:0] op3;
  logic alu_op, mem_op, ack, rd_zero;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] rd_sel;
  logic [DATAWIDTH_MUX_SELECTION-1:0] rs1_sel, rs2_sel, rd_mux, b_sel;
  assign op      = CC_MICROSEQUENCER_IR_OP[7:6];
  assign op3     = CC_MICROSEQUENCER_IR_OP[5:0];
  assign alu_op  = op == 2'b10 && op3 <= 6'd4;
  assign mem_op  = op == 2'b11 && (op3 == 6'd0 || op3 == 6'd4);
  assign ack     = CC_MICROSEQUENCER_MemAck_In;
  assign rd_zero = CC_MICROSEQUENCER_IR_RD == '0;
  assign rd_sel  = DATAWIDTH_DECODER_SELECTION'(CC_MICROSEQUENCER_IR_RD);
  assign rd_mux  = DATAWIDTH_MUX_SELECTION'(CC_MICROSEQUENCER_IR_RD);
  assign rs1_sel = DATAWIDTH_MUX_SELECTION'(CC_MICROSEQUENCER_IR_RS1);
  assign rs2_sel = DATAWIDTH_MUX_SELECTION'(CC_MICROSEQUENCER_IR_RS2);
  assign b_sel   = CC_MICROSEQUENCER_IR_IR13 ? M_SIMM : rs2_sel;
  always_ff @(posedge CC_MICROSEQUENCER_CLOCK_50 or negedge CC_MICROSEQUENCER_RESET_InLow)
    if (!CC_MICROSEQUENCER_RESET_InLow) begin
      state   <= S_RESET;
      retired <= '0;
    end else begin
      state   <= state_nx;
      retired <= state == S_PCINC ? retired + DATAWIDTH_COUNTER'(1) : retired;
    end
  always_comb begin
    state_nx = state;
    CC_MICROSEQUENCER_Decoder_Selection_Out = D_NONE;
    CC_MICROSEQUENCER_MUXA_Selection_Out    = '0;
    CC_MICROSEQUENCER_MUXB_Selection_Out    = '0;
    CC_MICROSEQUENCER_MUXC_Selection_Out    = 1'b0;
    CC_MICROSEQUENCER_ALU_Op_Out            = A_PASSA;
    CC_MICROSEQUENCER_MemReq_Out            = 1'b0;
    CC_MICROSEQUENCER_MemWrite_Out          = 1'b0;
    case (state)
      S_RESET: state_nx = S_FETCH;
      S_FETCH: begin
        CC_MICROSEQUENCER_MUXA_Selection_Out    = M_PC;
        CC_MICROSEQUENCER_MemReq_Out            = 1'b1;
        CC_MICROSEQUENCER_MUXC_Selection_Out    = 1'b1;
        CC_MICROSEQUENCER_Decoder_Selection_Out = ack ? D_IR : D_NONE;
        state_nx = ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_nx = alu_op ? S_EXEC : mem_op ? S_ADDR : S_HALT;
      S_EXEC: begin
        CC_MICROSEQUENCER_MUXA_Selection_Out    = rs1_sel;
        CC_MICROSEQUENCER_MUXB_Selection_Out    = b_sel;
        CC_MICROSEQUENCER_ALU_Op_Out            = DATAWIDTH_ALU_SELECTION'(op3[2:0]);
        CC_MICROSEQUENCER_Decoder_Selection_Out = rd_zero ? D_NONE : rd_sel;
        state_nx = S_PCINC;
      end
      S_ADDR: begin
        CC_MICROSEQUENCER_MUXA_Selection_Out    = rs1_sel;
        CC_MICROSEQUENCER_MUXB_Selection_Out    = b_sel;
        CC_MICROSEQUENCER_ALU_Op_Out            = A_ADD;
        CC_MICROSEQUENCER_Decoder_Selection_Out = D_T0;
        state_nx = S_MEM;
      end
      S_MEM: begin
        // op3[2] separates ST (4) from LD (0); only those two reach here
        CC_MICROSEQUENCER_MUXA_Selection_Out    = M_T0;
        CC_MICROSEQUENCER_MemReq_Out            = 1'b1;
        CC_MICROSEQUENCER_MUXB_Selection_Out    = op3[2] ? rd_mux : '0;
        CC_MICROSEQUENCER_MemWrite_Out          = op3[2];
        CC_MICROSEQUENCER_MUXC_Selection_Out    = !op3[2];
        CC_MICROSEQUENCER_Decoder_Selection_Out = (!op3[2] && ack && !rd_zero) ? rd_sel : D_NONE;
        state_nx = ack ? S_PCINC : S_MEM;
      end
      S_PCINC: begin
        CC_MICROSEQUENCER_MUXA_Selection_Out    = M_PC;
        CC_MICROSEQUENCER_ALU_Op_Out            = A_INC4;
        CC_MICROSEQUENCER_Decoder_Selection_Out = D_PC;
        state_nx = S_FETCH;
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_RESET;
    endcase
  end
  assign CC_MICROSEQUENCER_Halt_Out    = state == S_HALT;
  assign CC_MICROSEQUENCER_Retired_Out = retired;
endmodule

// File: tb/tb_cc_microsequencer.sv
// tb_cc_microsequencer: per-cycle expected output vectors queued by the driver, checked by a negedge monitor
module tb_cc_microsequencer;
  typedef struct packed {
    logic [3:0]  dec;
    logic [3:0]  ma;
    logic [3:0]  mb;
    logic        mc;
    logic [3:0]  alu;
    logic        req;
    logic        wr;
    logic        halt;
    logic [15:0] ret;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, ack = 1'b0, ir13 = 1'b0;
  logic [7:0] op = 8'h00;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  exp_t act, x;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc_n = 0;
  always #5 clk = ~clk;
  cc_microsequencer dut (
    .CC_MICROSEQUENCER_CLOCK_50(clk),
    .CC_MICROSEQUENCER_RESET_InLow(rst_n),
    .CC_MICROSEQUENCER_IR_OP(op),
    .CC_MICROSEQUENCER_IR_RS1(rs1),
    .CC_MICROSEQUENCER_IR_RS2(rs2),
    .CC_MICROSEQUENCER_IR_RD(rd),
    .CC_MICROSEQUENCER_IR_IR13(ir13),
    .CC_MICROSEQUENCER_MemAck_In(ack),
    .CC_MICROSEQUENCER_Decoder_Selection_Out(act.dec),
    .CC_MICROSEQUENCER_MUXA_Selection_Out(act.ma),
    .CC_MICROSEQUENCER_MUXB_Selection_Out(act.mb),
    .CC_MICROSEQUENCER_MUXC_Selection_Out(act.mc),
    .CC_MICROSEQUENCER_ALU_Op_Out(act.alu),
    .CC_MICROSEQUENCER_MemReq_Out(act.req),
    .CC_MICROSEQUENCER_MemWrite_Out(act.wr),
    .CC_MICROSEQUENCER_Halt_Out(act.halt),
    .CC_MICROSEQUENCER_Retired_Out(act.ret)
  );
  function automatic exp_t e(input logic [3:0] dec, ma, mb, input logic mc, input logic [3:0] alu,
                             input logic req, wr, halt, input logic [15:0] ret);
    return '{dec, ma, mb, mc, alu, req, wr, halt, ret};
  endfunction
  function automatic exp_t idle(input logic [15:0] ret);
    return e(4'hF, 0, 0, 0, 6, 0, 0, 0, ret);
  endfunction
  task automatic cyc(input logic r, input logic a, input exp_t v);
    @(posedge clk);
    #1;
    rst_n = r;
    ack = a;
    q.push_back(v);
  endtask
  task automatic ir(input logic [7:0] o, input logic [4:0] s1, s2, d, input logic i);
    op = o; rs1 = s1; rs2 = s2; rd = d; ir13 = i;
  endtask
  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (q.size() != 0) begin
      x = q.pop_front();
      n_chk++;
      if (act !== x) begin
        n_fail++;
        $display("FAIL vec@cyc%0d dec=%h/%h ma=%h/%h mb=%h/%h mc=%b/%b alu=%h/%h req=%b/%b wr=%b/%b halt=%b/%b ret=%0d/%0d (got/want)",
                 cyc_n, act.dec, x.dec, act.ma, x.ma, act.mb, x.mb, act.mc, x.mc, act.alu, x.alu,
                 act.req, x.req, act.wr, x.wr, act.halt, x.halt, act.ret, x.ret);
      end
    end
  end
  initial begin
    // power-on reset, then one RESET cycle after release
    ir(8'h80, 1, 2, 3, 0);
    cyc(0, 0, idle(0));
    cyc(1, 0, idle(0));
    // ADD r3 <- r1 + r2, zero-wait fetch
    cyc(1, 1, e(13, 8, 0, 1, 6, 1, 0, 0, 0));
    cyc(1, 0, idle(0));
    cyc(1, 0, e(3, 1, 2, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, e(8, 8, 0, 0, 5, 0, 0, 0, 0));
    // ADD r5 <- r1 + simm13
    ir(8'h80, 1, 2, 5, 1);
    cyc(1, 1, e(13, 8, 0, 1, 6, 1, 0, 0, 1));
    cyc(1, 0, idle(1));
    cyc(1, 0, e(5, 1, 14, 0, 0, 0, 0, 0, 1));
    cyc(1, 0, e(8, 8, 0, 0, 5, 0, 0, 0, 1));
    // SUB with RD=0 and a one-wait fetch: no write select
    ir(8'h84, 3, 4, 0, 0);
    cyc(1, 0, e(15, 8, 0, 1, 6, 1, 0, 0, 2));
    cyc(1, 1, e(13, 8, 0, 1, 6, 1, 0, 0, 2));
    cyc(1, 0, idle(2));
    cyc(1, 0, e(15, 3, 4, 0, 4, 0, 0, 0, 2));
    cyc(1, 0, e(8, 8, 0, 0, 5, 0, 0, 0, 2));
    // XOR r7 <- r2 ^ r3
    ir(8'h83, 2, 3, 7, 0);
    cyc(1, 1, e(13, 8, 0, 1, 6, 1, 0, 0, 3));
    cyc(1, 0, idle(3));
    cyc(1, 0, e(7, 2, 3, 0, 3, 0, 0, 0, 3));
    cyc(1, 0, e(8, 8, 0, 0, 5, 0, 0, 0, 3));
    // LD r4, stray ack in DECODE ignored, 3 wait cycles in MEM
    ir(8'hC0, 1, 2, 4, 0);
    cyc(1, 1, e(13, 8, 0, 1, 6, 1, 0, 0, 4));
    cyc(1, 1, idle(4));
    cyc(1, 0, e(9, 1, 2, 0, 0, 0, 0, 0, 4));
    for (int i = 0; i < 3; i++) cyc(1, 0, e(15, 9, 0, 1, 6, 1, 0, 0, 4));
    cyc(1, 1, e(4, 9, 0, 1, 6, 1, 0, 0, 4));
    cyc(1, 0, e(8, 8, 0, 0, 5, 0, 0, 0, 4));
    // ST r6 -> [r2 + simm13], zero-wait
    ir(8'hC4, 2, 3, 6, 1);
    cyc(1, 1, e(13, 8, 0, 1, 6, 1, 0, 0, 5));
    cyc(1, 0, idle(5));
    cyc(1, 0, e(9, 2, 14, 0, 0, 0, 0, 0, 5));
    cyc(1, 1, e(15, 9, 6, 0, 6, 1, 1, 0, 5));
    cyc(1, 0, e(8, 8, 0, 0, 5, 0, 0, 0, 5));
    // illegal opcode halts, acks ignored, count frozen
    ir(8'h3F, 1, 1, 1, 0);
    cyc(1, 1, e(13, 8, 0, 1, 6, 1, 0, 0, 6));
    cyc(1, 0, idle(6));
    for (int i = 0; i < 4; i++) cyc(1, i[0], e(15, 0, 0, 0, 6, 0, 0, 1, 6));
    // reset out of HALT, then reset mid-FETCH with MemReq high
    ir(8'h80, 1, 2, 3, 0);
    cyc(0, 0, idle(0));
    cyc(1, 0, idle(0));
    cyc(1, 0, e(15, 8, 0, 1, 6, 1, 0, 0, 0));
    cyc(0, 0, idle(0));
    cyc(1, 0, idle(0));
    cyc(1, 1, e(13, 8, 0, 1, 6, 1, 0, 0, 0));
    cyc(1, 0, idle(0));
    cyc(1, 0, e(3, 1, 2, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, e(8, 8, 0, 0, 5, 0, 0, 0, 0));
    cyc(1, 0, e(15, 8, 0, 1, 6, 1, 0, 0, 1));
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
